// File: rtl/sbox_lut_mp_pkg.sv
// sbox_pkg: shared FSM state encoding, default parameters and the AES forward S-box
package sbox_pkg;
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LANES = 4;
    localparam int DEF_READ_LAT = 2;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
endpackage

// File: rtl/sbox_lut_mp_bank.sv
// sbox_lut_bank: depth x DATA_WIDTH table, one write port, LANES registered read ports
// SBOX_ROM_INIT_EN: reset preloads the AES forward S-box
module sbox_lut_bank
    import sbox_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                         clk0,
    input  logic                         rst0,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic [LANES*ADDR_WIDTH-1:0]  rd_addr,
    output logic [LANES*DATA_WIDTH-1:0]  rd_data
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef SBOX_ROM_INIT_EN
    always_ff @(posedge clk0) begin
        if (rst0) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_WIDTH'(SBOX[i]);
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end
`else
    always_ff @(posedge clk0) begin
        if (we) mem[wr_addr] <= wr_data;
    end
`endif
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < LANES; i++)
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end
endmodule

// File: rtl/sbox_lut_mp.sv
// sbox_lut_mp: multi-lane substitution table with sequential load port and valid/ready lookup pipeline
// SBOX_ROM_INIT_EN: reset preloads the AES S-box and starts in READY
module sbox_lut_mp
    import sbox_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                         clk0,
    input  logic                         rst0,
    input  logic                         ld_start,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [DATA_WIDTH-1:0]        ld_data,
    output logic                         table_ready,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*ADDR_WIDTH-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*DATA_WIDTH-1:0]  out_data
);
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("READ_LAT must be 1 or 2");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("LANES must be 1..16");
    end
`ifdef SBOX_ROM_INIT_EN
    if (DATA_WIDTH != 8 || ADDR_WIDTH != 8) begin : g_bad_rom
        $error("SBOX_ROM_INIT_EN needs DATA_WIDTH=8 and ADDR_WIDTH=8");
    end
    localparam state_t RST_STATE = READY;
`else
    localparam state_t RST_STATE = EMPTY;
`endif
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic stall, accept, busy, we, vout;
    logic [LANES*DATA_WIDTH-1:0] rd_data;
    assign stall = vout && !out_ready;
    assign in_ready = state == READY && !ld_start && !stall;
    assign accept = in_valid && in_ready;
    assign ld_ready = state == LOADING;
    assign table_ready = state == READY;
    assign out_valid = vout;
    // a reset edge must not write, so the table keeps exactly the beats accepted before it
    assign we = ld_ready && ld_valid && !ld_start && !rst0;
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        case (state)
            EMPTY: begin
                if (ld_start) begin
                    state_nxt = LOADING;
                    cnt_nxt = '0;
                end
            end
            LOADING: begin
                if (ld_start) begin
                    cnt_nxt = '0;
                end else if (ld_valid) begin
                    cnt_nxt = cnt + 1'b1;
                    state_nxt = &cnt ? READY : LOADING;
                end
            end
            READY: begin
                if (ld_start && !busy) begin
                    state_nxt = LOADING;
                    cnt_nxt = '0;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state <= RST_STATE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end
    sbox_lut_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LANES(LANES)
    ) u_bank (
        .clk0(clk0),
        .rst0(rst0),
        .we(we),
        .wr_addr(cnt),
        .wr_data(ld_data),
        .rd_en(accept),
        .rd_addr(in_data),
        .rd_data(rd_data)
    );
    if (READ_LAT == 2) begin : g_lat2
        logic v1;
        logic [LANES*DATA_WIDTH-1:0] d2;
        always_ff @(posedge clk0) begin
            if (rst0) begin
                v1 <= 1'b0;
                vout <= 1'b0;
                d2 <= '0;
            end else if (!stall) begin
                v1 <= accept;
                vout <= v1;
                if (v1) d2 <= rd_data;
            end
        end
        assign busy = v1 || stall;
        assign out_data = d2;
    end else begin : g_lat1
        always_ff @(posedge clk0) begin
            if (rst0) vout <= 1'b0;
            else if (!stall) vout <= accept;
        end
        assign busy = stall;
        assign out_data = rd_data;
    end
endmodule
